// File: rtl/ggt_seq_if.sv
// ggt_seq_if: bundles the batch-control, memory and ggt_top signals of the
// ggt_seq batch sequencer.
//   go_i, pairs_i              batch start request and pair count
//   busy_o, done_o, err_o      batch status
//   mem_addr_o/data_o/wren_o   single-port memory request (sequencer drives)
//   mem_q_i                    memory read data, 2-cycle read latency
//   ggt_start_o/zahl1_o/zahl2_o  start pulse and operands to ggt_top
//   ggt_valid_i/ergebnis_i     result from ggt_top
// Modports: master = sequencer side, slave = memory/ggt_top/host side.
interface ggt_seq_if #(
    parameter int ADDR_W = 8
);
    logic              go_i;
    logic [ADDR_W-1:0] pairs_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [15:0]       mem_data_o;
    logic              mem_wren_o;
    logic [15:0]       mem_q_i;
    logic              ggt_start_o;
    logic [15:0]       ggt_zahl1_o;
    logic [15:0]       ggt_zahl2_o;
    logic              ggt_valid_i;
    logic [15:0]       ggt_ergebnis_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        input  go_i, pairs_i, mem_q_i, ggt_valid_i, ggt_ergebnis_i,
        output mem_addr_o, mem_data_o, mem_wren_o,
        output ggt_start_o, ggt_zahl1_o, ggt_zahl2_o,
        output busy_o, done_o, err_o
    );

    modport slave (
        output go_i, pairs_i, mem_q_i, ggt_valid_i, ggt_ergebnis_i,
        input  mem_addr_o, mem_data_o, mem_wren_o,
        input  ggt_start_o, ggt_zahl1_o, ggt_zahl2_o,
        input  busy_o, done_o, err_o
    );
endinterface

// File: rtl/ggt_seq.sv
// ggt_seq: batch sequencer in front of ggt_top. Reads operand pairs from the
// shared single-port memory (pair k: operands at 2k and 2k+1), pulses
// ggt_start_o once per pair, waits for ggt_valid_i and writes each result to
// RES_BASE+k. All address arithmetic wraps modulo 2^ADDR_W.
// Ports:
//   clk    rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    ggt_seq_if.master (batch control, memory port, ggt_top port)
// Parameters: ADDR_W (address width), RES_BASE (first result address),
//   TO_CYCLES (WAIT watchdog limit).
// Optional feature: define GGT_TIMEOUT_EN to enable the WAIT watchdog, which
// writes 16'hFFFF and sets the sticky err_o when no result arrives within
// TO_CYCLES cycles. Without it WAIT is unbounded and err_o is 0.
module ggt_seq #(
    parameter int ADDR_W    = 8,
    parameter int RES_BASE  = 128,
    parameter int TO_CYCLES = 4096
) (
    input  logic      clk,
    input  logic      rst_i,
    ggt_seq_if.master bus
);
    if (ADDR_W < 2 || TO_CYCLES < 1) begin : g_param_check
        $error("ggt_seq: ADDR_W must be >= 2 and TO_CYCLES >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, RDA, RDB, CAPA, CAPB, START, GUARD, WAIT, WRITE, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] pairs_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;
    logic              wren_q;
    logic              start_q;
    logic [15:0]       zahl1_q;
    logic [15:0]       zahl2_q;
    logic              busy_q;
    logic              done_q;

    // k+1 is kept one bit wider so the last-pair test cannot wrap.
    logic [ADDR_W:0]   k_inc;
    logic              last_pair;
    logic [ADDR_W-1:0] res_addr;
    logic [ADDR_W-1:0] rdb_addr;
    logic [ADDR_W-1:0] next_rda_addr;

    assign k_inc         = {1'b0, k} + (ADDR_W + 1)'(1);
    assign last_pair     = (k_inc >= {1'b0, pairs_q});
    assign res_addr      = k + ADDR_W'(RES_BASE);
    assign rdb_addr      = {k[ADDR_W-2:0], 1'b1};
    assign next_rda_addr = {k_inc[ADDR_W-2:0], 1'b0};

`ifdef GGT_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    // Outputs are registered: each is loaded on the edge that enters the
    // state in which it must be visible.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            k       <= '0;
            pairs_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            start_q <= 1'b0;
            zahl1_q <= '0;
            zahl2_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GGT_TIMEOUT_EN
            to_cnt  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go_i) begin
                        pairs_q <= bus.pairs_i;
                        k       <= '0;
                        busy_q  <= 1'b1;
`ifdef GGT_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        if (bus.pairs_i == '0) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            addr_q <= '0;
                            state  <= RDA;
                        end
                    end
                end
                RDA: begin
                    addr_q <= rdb_addr;
                    state  <= RDB;
                end
                RDB: state <= CAPA;
                CAPA: begin
                    zahl1_q <= bus.mem_q_i;
                    state   <= CAPB;
                end
                CAPB: begin
                    zahl2_q <= bus.mem_q_i;
                    start_q <= 1'b1;
                    state   <= START;
                end
                START: state <= GUARD;
                GUARD: begin
`ifdef GGT_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.ggt_valid_i) begin
                        data_q <= bus.ggt_ergebnis_i;
                        addr_q <= res_addr;
                        wren_q <= 1'b1;
                        state  <= WRITE;
                    end
`ifdef GGT_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        data_q <= 16'hFFFF;
                        addr_q <= res_addr;
                        wren_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                WRITE: begin
                    if (!last_pair) begin
                        k      <= k_inc[ADDR_W-1:0];
                        addr_q <= next_rda_addr;
                        state  <= RDA;
                    end else begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_data_o  = data_q;
    assign bus.mem_wren_o  = wren_q;
    assign bus.ggt_start_o = start_q;
    assign bus.ggt_zahl1_o = zahl1_q;
    assign bus.ggt_zahl2_o = zahl2_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
endmodule

// File: tb/tb_ggt_seq.sv
// tb_ggt_seq: scoreboard bench for ggt_seq. A memory model with 2-cycle read
// latency and a ggt_top stub (random latency, stale valid held until after
// the start pulse) surround the DUT. Expected start operands and result
// writes come from the memory contents and a plain Euclid model; a monitor
// pops and compares them whenever the DUT presents a start or a write.
module tb_ggt_seq;
    localparam int ADDR_W   = 8;
    localparam int RES_BASE = 128;
`ifdef GGT_TIMEOUT_EN
    localparam int TO_CYC   = 16;
`else
    localparam int TO_CYC   = 4096;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ggt_seq_if #(.ADDR_W(ADDR_W)) bus ();

    ggt_seq #(
        .ADDR_W   (ADDR_W),
        .RES_BASE (RES_BASE),
        .TO_CYCLES(TO_CYC)
    ) dut (
        .clk  (clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int go_cyc   = -1000;
    int cur_pairs = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gcd(input int a, input int b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Operand memory; result writes are checked by the monitor, not stored.
    logic [15:0] mem [256];
    logic [7:0]  rd_a;
    logic [15:0] rd_q;
    always @(posedge clk) begin
        rd_a <= bus.mem_addr_o;
        rd_q <= mem[rd_a];
    end
    assign bus.mem_q_i = rd_q;

    // ggt_top stub
    logic        stub_valid = 1'b0;
    logic [15:0] stub_erg   = '0;
    logic [15:0] stub_res   = '0;
    int          stub_cd    = 0;
    bit          stub_pend  = 1'b0;
    int          lat_fixed  = -1;
    bit          never_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            stub_pend  <= 1'b0;
            stub_valid <= 1'b0;
        end else if (bus.ggt_start_o) begin
            stub_res  <= 16'(gcd(int'(bus.ggt_zahl1_o), int'(bus.ggt_zahl2_o)));
            stub_cd   <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 6));
            stub_pend <= 1'b1;
        end else if (stub_pend) begin
            if (!never_valid && stub_cd == 0) begin
                stub_valid <= 1'b1;
                stub_erg   <= stub_res;
                stub_pend  <= 1'b0;
            end else begin
                stub_valid <= 1'b0;
                stub_erg   <= 16'hDEAD;
                if (stub_cd > 0) stub_cd <= stub_cd - 1;
            end
        end
    end
    assign bus.ggt_valid_i    = stub_valid;
    assign bus.ggt_ergebnis_i = stub_erg;

    // Scoreboard queues
    typedef struct { int a; int b; } start_t;
    typedef struct { int addr; int data; int rel; } wr_t;
    start_t exp_start[$];
    wr_t    exp_wr[$];

    // Monitor
    int last_wr_cyc = 0;
    always @(negedge clk) begin
        if (!rst) begin
            int rel;
            start_t s;
            wr_t w;
            rel = cyc - go_cyc;
            if (cur_pairs != 0 && rel == 1) chk("rda_addr", int'(bus.mem_addr_o), 0);
            if (cur_pairs != 0 && rel == 5) chk("start_cycle5", int'(bus.ggt_start_o), 1);
            if (bus.ggt_start_o) begin
                chk("start_wren_excl", int'(bus.mem_wren_o), 0);
                if (exp_start.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    s = exp_start.pop_front();
                    chk("zahl1", int'(bus.ggt_zahl1_o), s.a);
                    chk("zahl2", int'(bus.ggt_zahl2_o), s.b);
                end
            end
            if (bus.mem_wren_o) begin
                if (exp_wr.size() == 0) begin
                    chk("write_unexpected", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", int'(bus.mem_addr_o), w.addr);
                    chk("wr_data", int'(bus.mem_data_o), w.data);
                    if (w.rel >= 0) chk("wr_cycle", rel, w.rel);
                end
                last_wr_cyc = cyc;
            end
            if (bus.done_o) begin
                done_cnt++;
                if (cur_pairs == 0) chk("done_cycle", rel, 1);
                else                chk("done_after_write", cyc - last_wr_cyc, 1);
                chk("busy_in_done", int'(bus.busy_o), 1);
            end
        end
    end

    task automatic add_pair(input int k, input int a, input int b, input int res, input int rel);
        mem[2*k]     = 16'(a);
        mem[2*k + 1] = 16'(b);
        exp_start.push_back('{a: a, b: b});
        exp_wr.push_back('{addr: (RES_BASE + k) % 256, data: res, rel: rel});
    endtask

    task automatic add_random_pairs(input int n);
        for (int k = 0; k < n; k++) begin
            int g = int'($urandom_range(1, 200));
            int a = g * int'($urandom_range(1, 300));
            int b = g * int'($urandom_range(1, 300));
            add_pair(k, a, b, gcd(a, b), -1);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},  int'(bus.mem_addr_o), 0);
        chk({tag, "_data"},  int'(bus.mem_data_o), 0);
        chk({tag, "_zahl1"}, int'(bus.ggt_zahl1_o), 0);
        chk({tag, "_zahl2"}, int'(bus.ggt_zahl2_o), 0);
        chk({tag, "_flags"}, int'({bus.mem_wren_o, bus.ggt_start_o, bus.busy_o,
                                   bus.done_o, bus.err_o}), 0);
    endtask

    task automatic start_go(input int n);
        @(negedge clk);
        bus.pairs_i = 8'(n);
        bus.go_i    = 1'b1;
        go_cyc      = cyc;
        cur_pairs   = n;
    endtask

    task automatic launch(input int n, input bit hold, input int exp_err, input int budget);
        int d0;
        bit got;
        d0 = done_cnt;
        start_go(n);
        @(negedge clk);
        if (!hold) bus.go_i = 1'b0;
        bus.pairs_i = 8'($urandom);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.go_i = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("busy_after", int'(bus.busy_o), 0);
        chk("err_flag", int'(bus.err_o), exp_err);
    endtask

    initial begin
        rst         = 1'b1;
        bus.go_i    = 1'b0;
        bus.pairs_i = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single pair, fixed zero stub latency: write lands in cycle 8
        lat_fixed = 0;
        add_pair(0, 48, 18, 6, 8);
        launch(1, 1'b0, 0, 50);

        // three directed pairs, random latency
        lat_fixed = -1;
        add_pair(0, 12, 8, 4, -1);
        add_pair(1, 35, 14, 7, -1);
        add_pair(2, 17, 5, 1, -1);
        launch(3, 1'b0, 0, 100);

        // empty batch
        launch(0, 1'b0, 0, 10);

        // go held high for the whole batch
        add_random_pairs(4);
        launch(4, 1'b1, 0, 120);

        // randomized batches
        for (int r = 0; r < 4; r++) begin
            int n = int'($urandom_range(1, 12));
            add_random_pairs(n);
            launch(n, 1'b0, 0, 20 * n + 20);
        end

        // asynchronous reset during WAIT of the second pair
        lat_fixed = 30;
        add_random_pairs(3);
        start_go(3);
        @(negedge clk);
        bus.go_i = 1'b0;
        for (int i = 0; i < 200 && (cyc - go_cyc) < 50; i++) @(negedge clk);
        chk("busy_mid_batch", int'(bus.busy_o), 1);
        #2 rst = 1'b1;
        #1 chk_reset("async_reset");
        exp_start.delete();
        exp_wr.delete();
        @(negedge clk);
        rst = 1'b0;
        lat_fixed = -1;
        add_pair(0, 1000, 600, 200, -1);
        add_pair(1, 81, 27, 27, -1);
        launch(2, 1'b0, 0, 60);

`ifdef GGT_TIMEOUT_EN
        // watchdog: no valid ever, 16 WAIT cycles then write 16'hFFFF
        never_valid = 1'b1;
        add_pair(0, 100, 75, 16'hFFFF, 23);
        launch(1, 1'b0, 1, 60);
        never_valid = 1'b0;
        add_random_pairs(2);
        launch(2, 1'b0, 0, 60);
`endif

        repeat (5) @(negedge clk);
        chk("start_queue_empty", exp_start.size(), 0);
        chk("write_queue_empty", exp_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ggt_seq.md
# ggt_seq

Batch sequencer that sits directly upstream of `ggt_top`. It reads operand pairs from the on-chip single-port memory (`LEDM`) and issues one `start_i` pulse per pair. It waits for `valid_o`, then writes each `ergebnis_o` back into a result region of the same memory. This replaces file-driven stimulus on the FPGA target and lets a whole batch run without a host.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `RES_BASE`, 128: address of the first result word.
- `TO_CYCLES`, 4096: watchdog limit in WAIT cycles; only used with `GGT_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `go_i`  in  1  batch start; sampled only in IDLE.
- `pairs_i`  in  ADDR_W  number of operand pairs; captured when `go_i` is accepted.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_data_o`  out  16  memory write data.
- `mem_wren_o`  out  1  memory write enable.
- `mem_q_i`  in  16  memory read data; 2-cycle read latency (address registered, output registered).
- `ggt_start_o`  out  1  one-cycle start pulse to `ggt_top`.
- `ggt_zahl1_o`  out  16  operand 1 to `ggt_top`.
- `ggt_zahl2_o`  out  16  operand 2 to `ggt_top`.
- `ggt_valid_i`  in  1  `ggt_top` result valid (level).
- `ggt_ergebnis_i`  in  16  `ggt_top` result.
- `busy_o`  out  1  batch in progress.
- `done_o`  out  1  one-cycle pulse at batch end.
- `err_o`  out  1  sticky timeout flag.

## Operation
- Memory layout: pair k has operand 1 at address 2k and operand 2 at 2k+1; its result goes to `RES_BASE`+k.
- All address arithmetic is modulo 2^ADDR_W and wraps silently.
- Pair index k is an ADDR_W-bit counter. It resets to 0 on each accepted `go_i`.
- States: IDLE, RDA, RDB, CAPA, CAPB, START, GUARD, WAIT, WRITE, DONE.
- IDLE: when `go_i`=1, capture `pairs_i` and clear `err_o`.
  - If `pairs_i`=0, go to DONE.
  - Otherwise go to RDA.
- RDA: `mem_addr_o`=2k. Go to RDB.
- RDB: `mem_addr_o`=2k+1. Go to CAPA.
- CAPA: register `mem_q_i` into `ggt_zahl1_o`. Go to CAPB.
- CAPB: register `mem_q_i` into `ggt_zahl2_o`. Go to START.
- START: `ggt_start_o`=1 for exactly this cycle. Go to GUARD.
- GUARD: one cycle; `ggt_valid_i` is ignored, which masks a stale valid from the previous pair. Go to WAIT.
- WAIT: stay until `ggt_valid_i`=1, then go to WRITE.
- WRITE: for one cycle drive `mem_wren_o`=1, `mem_addr_o`=`RES_BASE`+k, `mem_data_o`=`ggt_ergebnis_i` (captured on WAIT exit).
  - If k+1 < pairs, increment k and go to RDA.
  - Otherwise go to DONE.
- DONE: `done_o`=1 for one cycle. Go to IDLE.
- `busy_o`=1 in every state except IDLE.
- `go_i` outside IDLE is ignored. `pairs_i` changes after capture have no effect.
- `ggt_zahl1_o`/`ggt_zahl2_o` hold stable from CAPB until the next CAPA.

## Timing
- Reset values: `mem_addr_o`=0, `mem_data_o`=0, `mem_wren_o`=0, `ggt_start_o`=0, `ggt_zahl1_o`=0, `ggt_zahl2_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0; state IDLE; k=0.
- Reset is asynchronous. Asserting `rst_i` mid-batch forces the reset values immediately, including dropping `mem_wren_o`. No resume: the next `go_i` restarts at pair 0.
- All outputs are registered.
- With `go_i` accepted at edge E0:
  - RDA is cycle 1.
  - `ggt_start_o` is high in cycle 5.
  - WAIT is entered in cycle 7 at the earliest.
- Per-pair overhead is 8 cycles plus the `ggt_top` compute time, counted from RDA through WRITE with one WAIT cycle.
- The `done_o` pulse occurs in the cycle after the last WRITE.
- With `pairs_i`=0, `done_o` is high in cycle 1 and there is no memory or `ggt_start_o` activity.
- `ggt_start_o` and `mem_wren_o` are never high in the same cycle.

## Configuration
- Macro: `GGT_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT and clears on WAIT entry.
  - When it reaches `TO_CYCLES` without valid, go to WRITE with `mem_data_o`=16'hFFFF and set `err_o`=1.
  - `err_o` stays set until the next accepted `go_i` or reset.
  - The batch continues with the next pair.
- Not defined: WAIT waits indefinitely, `err_o` is tied to 0 and the counter is not instantiated.

## Test plan
- Reset with `rst_i`=1 mid-stream -> all outputs 0 asynchronously, `busy_o`=0.
- mem[0]=48, mem[1]=18, `pairs_i`=1, `go_i` pulse -> `ggt_start_o` in cycle 5 with 48/18; after valid with 6, a single `mem_wren_o` cycle writes address 128, data 6; `done_o` pulses the next cycle.
- Pairs (12,8), (35,14), (17,5) with `pairs_i`=3 -> three start pulses; writes 4, 7, 1 to addresses 128, 129, 130; one `done_o`.
- `pairs_i`=0 -> `done_o` in cycle 1; no `mem_wren_o` and no `ggt_start_o`.
- `go_i` held high throughout a batch -> ignored while busy.
- `rst_i` pulse during WAIT of pair 2 -> outputs 0; a new `go_i` restarts reading at address 0.
- With `GGT_TIMEOUT_EN` defined, `TO_CYCLES`=16 and a stub that never asserts valid -> write 16'hFFFF to address 128 after 16 WAIT cycles, `err_o`=1, then `done_o`.
